keypad_scan_ctrl: RTL and testbench

//  Sequences the 4x4 hex keypad: drives shift_col one column at a time, samples
//  row, debounces, and issues one registered key code plus a one-cycle strobe
//  per press. Replaces the test_value stub in vending_machine as the source of
//  key codes for the coin/selection FSM and the D0..D2 display path.

---
 rtl/keypad_scan_ctrl_if.sv | 25 ++
 rtl/keypad_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scan bus: matrix row/column lines plus the decoded key outputs.
// master = scan controller, slave = matrix/consumer side.
interface keypad_scan_ctrl_if;
    logic [3:0] row;
    logic [3:0] shift_col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output shift_col,
        output key_value,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  shift_col,
        input  key_value,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 hex keypad scanner: column drive, row sync, debounce, one key code + strobe per press.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_RATE    = 10
`endif
) (
    input  logic               clk,
    input  logic               reset,
    keypad_scan_ctrl_if.master kp
);

    localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
`endif

    // Key map indexed by {row, col}
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]         row_meta;
    logic [3:0]         row_sync;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [1:0]         col_idx;
    logic [3:0]         shift_col;
    logic               acc_hit;
    logic               acc_multi;
    logic [3:0]         acc_code;

    logic               col_end;
    logic               scan_end;
    logic [3:0]         rows_low;
    logic               col_hit;
    logic               col_one;
    logic [1:0]         row_idx;
    logic [3:0]         col_code;
    logic               scan_hit;
    logic               scan_multi;
    logic [3:0]         scan_code;
    logic               scan_single;

    logic [1:0]         state,     state_nxt;
    logic [3:0]         cand,      cand_nxt;
    logic [CNT_W-1:0]   cnt,       cnt_nxt;
    logic [3:0]         key_value, key_value_nxt;
    logic               key_valid, key_valid_nxt;
    logic               key_held,  key_held_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit_cand;

`ifdef KEYPAD_REPEAT_EN
    logic [REP_W-1:0]   rep_cnt,   rep_cnt_nxt;
    logic               rep_armed, rep_armed_nxt;
    logic [REP_W-1:0]   rep_inc;
`endif

    assign col_end  = (dwell_cnt == DWELL_W'(SCAN_DIV - 1));
    assign scan_end = col_end && (col_idx == 2'd3);
    assign rows_low = ~row_sync;
    assign col_hit  = |rows_low;
    assign col_one  = col_hit && ((rows_low & (rows_low - 4'd1)) == 4'd0);

    // Row index is only meaningful when exactly one row is low
    always_comb begin
        row_idx = 2'd0;
        case (rows_low)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    assign col_code    = key_code(row_idx, col_idx);
    assign scan_hit    = acc_hit | col_hit;
    assign scan_multi  = acc_multi | (col_hit & (acc_hit | ~col_one));
    assign scan_code   = col_hit ? col_code : acc_code;
    assign scan_single = scan_hit & ~scan_multi;

    // Row synchronizer, column dwell/rotation and per-scan accumulation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta  <= 4'b1111;
            row_sync  <= 4'b1111;
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            shift_col <= 4'b1110;
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'h0;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
            if (col_end) begin
                dwell_cnt <= '0;
                col_idx   <= col_idx + 2'd1;
                shift_col <= {shift_col[2:0], shift_col[3]};
                if (col_idx == 2'd3) begin
                    acc_hit   <= 1'b0;
                    acc_multi <= 1'b0;
                    acc_code  <= 4'h0;
                end else begin
                    acc_hit   <= scan_hit;
                    acc_multi <= scan_multi;
                    acc_code  <= scan_code;
                end
            end else begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
        end
    end

    assign cnt_inc  = (cnt >= CNT_W'(DEBOUNCE_SCANS)) ? cnt : cnt + CNT_W'(1);
    assign hit_cand = scan_single && (scan_code == cand);
`ifdef KEYPAD_REPEAT_EN
    assign rep_inc  = (rep_cnt == REP_W'(REP_MAX)) ? rep_cnt : rep_cnt + REP_W'(1);
`endif

    // Debounce FSM, advanced once per completed scan
    always_comb begin
        state_nxt     = state;
        cand_nxt      = cand;
        cnt_nxt       = cnt;
        key_value_nxt = key_value;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_nxt   = rep_cnt;
        rep_armed_nxt = rep_armed;
`endif
        if (scan_end) begin
            case (state)
                ST_IDLE: begin
                    if (scan_single) begin
                        cand_nxt  = scan_code;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!scan_single) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else if (hit_cand) begin
                        cnt_nxt   = cnt_inc;
                    end else begin
                        cand_nxt  = scan_code;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!hit_cand) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if ((!rep_armed && rep_inc == REP_W'(REPEAT_DELAY)) ||
                             ( rep_armed && rep_inc == REP_W'(REPEAT_RATE))) begin
                        key_valid_nxt = 1'b1;
                        rep_cnt_nxt   = '0;
                        rep_armed_nxt = 1'b1;
                    end else begin
                        rep_cnt_nxt   = rep_inc;
                    end
`endif
                end
                default: begin
                    if (hit_cand) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_PRESSED;
                    end else begin
                        cnt_nxt   = cnt_inc;
                    end
                end
            endcase

            if (state_nxt == ST_DEBOUNCE && cnt_nxt >= CNT_W'(DEBOUNCE_SCANS)) begin
                key_value_nxt = cand_nxt;
                key_valid_nxt = 1'b1;
                key_held_nxt  = 1'b1;
                cnt_nxt       = '0;
                state_nxt     = ST_PRESSED;
            end

            if (state_nxt == ST_RELEASE && cnt_nxt >= CNT_W'(DEBOUNCE_SCANS)) begin
                key_held_nxt  = 1'b0;
                cnt_nxt       = '0;
                state_nxt     = ST_IDLE;
            end
        end
`ifdef KEYPAD_REPEAT_EN
        // Any entry into or exit from PRESSED restarts the initial delay
        if (state_nxt != ST_PRESSED || state != ST_PRESSED) begin
            rep_cnt_nxt   = '0;
            rep_armed_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cand      <= 4'h0;
            cnt       <= '0;
            key_value <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            key_value <= key_value_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= rep_cnt_nxt;
            rep_armed <= rep_armed_nxt;
`endif
        end
    end

    assign kp.shift_col = shift_col;
    assign kp.key_value = key_value;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE_SCANS=2).
module tb_keypad_scan_ctrl;

    localparam int unsigned SCAN_CLKS = 16;
`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned EXP_HOLD_STROBES = 4;
`else
    localparam int unsigned EXP_HOLD_STROBES = 1;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] keys;
    logic [3:0]  row_model;
    int          tests;
    int          fails;
    int          strobe_cnt;
    int          base;

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY   (3),
        .REPEAT_RATE    (2)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix: row r pulled low when key[r][c] is down and column c is driven low
    always_comb begin
        row_model = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.shift_col[c]) row_model[r] = 1'b0;
    end
    assign kif.row = row_model;

    initial strobe_cnt = 0;
    always @(posedge clk) if (kif.key_valid === 1'b1) strobe_cnt = strobe_cnt + 1;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scans(input int n);
        clocks(n * SCAN_CLKS);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        keys  = 16'h0;
        reset = 1'b0;
        clocks(3);
        check("rst_shift_col", kif.shift_col, 4'b1110);
        check("rst_key_value", kif.key_value, 4'h0);
        check("rst_key_valid", 4'(kif.key_valid), 4'd0);
        check("rst_key_held",  4'(kif.key_held),  4'd0);
        reset = 1'b1;

        // Column rotation
        clocks(3);
        check("col_dwell_3clk", kif.shift_col, 4'b1110);
        clocks(1);
        check("col_after_4clk", kif.shift_col, 4'b1101);
        clocks(12);
        check("col_wrap_16clk", kif.shift_col, 4'b1110);

        // Single press of '5'
        base = strobe_cnt;
        keys[5] = 1'b1;
        scans(2);
        check("k5_valid_hi", 4'(kif.key_valid), 4'd1);
        check("k5_value",    kif.key_value, 4'h5);
        check("k5_held",     4'(kif.key_held), 4'd1);
        clocks(1);
        check("k5_valid_one_clk", 4'(kif.key_valid), 4'd0);
        clocks(2 * SCAN_CLKS - 1);
        keys[5] = 1'b0;
        scans(1);
        check("k5_held_1_empty", 4'(kif.key_held), 4'd1);
        scans(1);
        check("k5_held_2_empty", 4'(kif.key_held), 4'd0);
        check("k5_strobes", 4'(strobe_cnt - base), 4'd1);

        // 'C' bouncing for three scan pairs, then held
        base = strobe_cnt;
        for (int i = 0; i < 3; i++) begin
            keys[11] = 1'b1;
            scans(1);
            keys[11] = 1'b0;
            scans(1);
        end
        check("kc_bounce_strobes", 4'(strobe_cnt - base), 4'd0);
        keys[11] = 1'b1;
        scans(1);
        check("kc_one_stable_scan", 4'(strobe_cnt - base), 4'd0);
        scans(1);
        check("kc_valid_hi", 4'(kif.key_valid), 4'd1);
        check("kc_value",    kif.key_value, 4'hC);
        clocks(SCAN_CLKS);
        keys[11] = 1'b0;
        scans(2);
        check("kc_released", 4'(kif.key_held), 4'd0);
        check("kc_strobes",  4'(strobe_cnt - base), 4'd1);

        // '1' and '2' together: rejected as multi-key
        base = strobe_cnt;
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        scans(4);
        check("multi_strobes", 4'(strobe_cnt - base), 4'd0);
        check("multi_value",   kif.key_value, 4'hC);
        check("multi_held",    4'(kif.key_held), 4'd0);
        keys[0] = 1'b0;
        keys[1] = 1'b0;
        scans(1);

        // '8' interrupted by reset mid-debounce, then re-qualifies
        base = strobe_cnt;
        keys[9] = 1'b1;
        scans(1);
        clocks(5);
        reset = 1'b0;
        clocks(1);
        check("k8_rst_shift_col", kif.shift_col, 4'b1110);
        check("k8_rst_value",     kif.key_value, 4'h0);
        check("k8_rst_valid",     4'(kif.key_valid), 4'd0);
        check("k8_rst_held",      4'(kif.key_held), 4'd0);
        clocks(1);
        reset = 1'b1;
        scans(1);
        check("k8_no_early_strobe", 4'(strobe_cnt - base), 4'd0);
        scans(1);
        check("k8_valid_hi", 4'(kif.key_valid), 4'd1);
        check("k8_value",    kif.key_value, 4'h8);
        clocks(SCAN_CLKS);
        keys[9] = 1'b0;
        scans(2);
        check("k8_released", 4'(kif.key_held), 4'd0);
        check("k8_strobes",  4'(strobe_cnt - base), 4'd1);

        // 'E' held for ten scans: repeat strobes only when auto-repeat is built in
        base = strobe_cnt;
        keys[12] = 1'b1;
        scans(2);
        check("ke_value", kif.key_value, 4'hE);
        scans(8);
        keys[12] = 1'b0;
        scans(3);
        check("ke_held_strobes", 4'(strobe_cnt - base), 4'(EXP_HOLD_STROBES));
        check("ke_released",     4'(kif.key_held), 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
